// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions for decode_issue_stage: opcodes, field positions,
// the decoded-instruction record and the decode function.
package decode_issue_stage_pkg;

    localparam int DW   = 20;
    localparam int NREG = 8;
    localparam int AW   = 4;

    localparam int OPC_LSB  = 16;
    localparam int DEST_LSB = 12;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 4;
    localparam int IMM_LSB  = 0;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_ALU_FIRST = 4'h1;
    localparam logic [3:0] OP_ALU_LAST  = 4'h7;
    localparam logic [3:0] OP_LDI       = 4'h8;
    localparam logic [3:0] OP_ADDI      = 4'h9;
    localparam logic [3:0] OP_LD        = 4'hA;
    localparam logic [3:0] OP_ST        = 4'hB;
    localparam logic [3:0] OP_BEQ       = 4'hC;

    typedef struct packed {
        logic [3:0]    opcode;
        logic [AW-1:0] dest;
        logic [AW-1:0] src1;
        logic [AW-1:0] src2;
        logic [7:0]    imm;
        logic          r1_en;
        logic          r2_en;
        logic          we;
        logic          illegal;
    } dec_t;

    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return idx < AW'(NREG);
    endfunction

    function automatic dec_t decode(input logic [DW-1:0] instr);
        dec_t          d;
        logic [3:0]    op;
        logic [AW-1:0] f_dest;
        logic [AW-1:0] f_src1;
        logic [AW-1:0] r2_idx;
        logic          u1;
        logic          u2;
        logic          w;
        logic          bad;
        op     = instr[OPC_LSB +: 4];
        f_dest = instr[DEST_LSB +: AW];
        f_src1 = instr[SRC1_LSB +: AW];
        r2_idx = (op == OP_ST) ? f_dest : instr[SRC2_LSB +: AW];
        u1  = 1'b0;
        u2  = 1'b0;
        w   = 1'b0;
        bad = 1'b0;
        if (op == OP_NOP) begin
            bad = 1'b0;
        end else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) begin
            u1 = 1'b1; u2 = 1'b1; w = 1'b1;
        end else if (op == OP_LDI) begin
            w = 1'b1;
        end else if (op == OP_ADDI || op == OP_LD) begin
            u1 = 1'b1; w = 1'b1;
        end else if (op == OP_ST) begin
            u1 = 1'b1; u2 = 1'b1;
        end else if (op == OP_BEQ) begin
            u1 = 1'b1; u2 = 1'b1;
        end else begin
            bad = 1'b1;
        end
        // Only fields the opcode actually uses can make it illegal.
        bad = bad || (u1 && !idx_ok(f_src1)) || (u2 && !idx_ok(r2_idx))
                  || (w && !idx_ok(f_dest));
        d         = '0;
        d.opcode  = op;
        d.dest    = f_dest;
        d.imm     = instr[IMM_LSB +: 8];
        d.illegal = bad;
        if (!bad) begin
            d.r1_en = u1;
            d.r2_en = u2;
            d.we    = w;
            d.src1  = u1 ? f_src1 : '0;
            d.src2  = u2 ? r2_idx : '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch, execute and writeback signals of decode_issue_stage.
// slave: the decode stage; master: the surrounding pipeline.
interface decode_issue_stage_if
    import decode_issue_stage_pkg::*;
    ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_opcode;
    logic [AW-1:0] out_dest;
    logic [AW-1:0] Reg1;
    logic [AW-1:0] Reg2;
    logic [7:0]    out_imm;
    logic          out_we;
    logic          out_illegal;
    logic          wb_valid;
    logic [AW-1:0] wb_dest;

    modport slave (
        input  in_valid, in_instr, flush, out_ready, wb_valid, wb_dest,
        output in_ready, out_valid, out_opcode, out_dest, Reg1, Reg2,
               out_imm, out_we, out_illegal
    );

    modport master (
        output in_valid, in_instr, flush, out_ready, wb_valid, wb_dest,
        input  in_ready, out_valid, out_opcode, out_dest, Reg1, Reg2,
               out_imm, out_we, out_illegal
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with a
// combinational hazard query for three register indices.
module decode_scoreboard
    import decode_issue_stage_pkg::*;
(
    input  logic                clk,
    input  logic                Reset,
    input  logic                set_en,
    input  logic [AW-1:0]       set_idx,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_idx,
    input  logic                held_en,
    input  logic [AW-1:0]       held_idx,
    input  logic [2:0]          q_en,
    input  logic [2:0][AW-1:0]  q_idx,
    output logic                hazard,
    output logic [NREG-1:0]     pending
);

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            oh[i] = (idx == AW'(i));
        end
        return oh;
    endfunction

    logic [NREG-1:0] set_oh;
    logic [NREG-1:0] clr_oh;
    logic [NREG-1:0] busy;

    assign set_oh = set_en  ? onehot(set_idx) : '0;
    assign clr_oh = clr_en  ? onehot(clr_idx) : '0;
    // A retiring write frees its register this cycle; the held output is
    // already committed to write even though it is not yet in the vector.
    assign busy   = (pending & ~clr_oh) | (held_en ? onehot(held_idx) : '0);

    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (q_en[k] && |(busy & onehot(q_idx[k]))) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_oh) | set_oh;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage with register scoreboard and RAW/WAW stall.
// Optional `define DECODE_PERF_CNT_EN adds the saturating stall_cnt output.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset,
    decode_issue_stage_if.slave  bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    dec_t            dec;
    logic            hazard;
    logic            accept;
    logic            issue_we;
    logic [NREG-1:0] pending;

    assign dec      = decode(bus.in_instr);
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && bus.in_ready;
    assign issue_we = bus.out_valid && bus.out_ready && bus.out_we && !bus.flush;

    decode_scoreboard u_sb (
        .clk      (clk),
        .Reset    (Reset),
        .set_en   (issue_we),
        .set_idx  (bus.out_dest),
        .clr_en   (bus.wb_valid),
        .clr_idx  (bus.wb_dest),
        .held_en  (bus.out_valid && bus.out_we),
        .held_idx (bus.out_dest),
        .q_en     ({dec.we, dec.r2_en, dec.r1_en}),
        .q_idx    ({dec.dest, dec.src2, dec.src1}),
        .hazard   (hazard),
        .pending  (pending)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_opcode  <= '0;
            bus.out_dest    <= '0;
            bus.Reg1        <= '0;
            bus.Reg2        <= '0;
            bus.out_imm     <= '0;
            bus.out_we      <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_opcode  <= dec.opcode;
            bus.out_dest    <= dec.dest;
            bus.Reg1        <= dec.src1;
            bus.Reg2        <= dec.src2;
            bus.out_imm     <= dec.imm;
            bus.out_we      <= dec.we;
            bus.out_illegal <= dec.illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && hazard && !bus.flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage: decode vector table
// plus hand-written stall, backpressure, flush and scoreboard sequences.
module tb_decode_issue_stage;
    import decode_issue_stage_pkg::*;

    logic clk;
    logic Reset;
    int   errors;
    int   checks;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    decode_issue_stage_if bus ();

    decode_issue_stage dut (
        .clk       (clk),
        .Reset     (Reset),
        .bus       (bus.slave)
`ifdef DECODE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  opc;
        logic [3:0]  dest;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [7:0]  imm;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_dest   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b0;
        idle_inputs();

        vt[0]  = '{20'h13120, 4'h1, 4'h3, 4'h1, 4'h2, 8'h20, 1'b1, 1'b0};
        vt[1]  = '{20'h850AB, 4'h8, 4'h5, 4'h0, 4'h0, 8'hAB, 1'b1, 1'b0};
        vt[2]  = '{20'h924FF, 4'h9, 4'h2, 4'h4, 4'h0, 8'hFF, 1'b1, 1'b0};
        vt[3]  = '{20'hB6305, 4'hB, 4'h6, 4'h3, 4'h6, 8'h05, 1'b0, 1'b0};
        vt[4]  = '{20'hCF170, 4'hC, 4'hF, 4'h1, 4'h7, 8'h70, 1'b0, 1'b0};
        vt[5]  = '{20'h09999, 4'h0, 4'h9, 4'h0, 4'h0, 8'h99, 1'b0, 1'b0};
        vt[6]  = '{20'hE1234, 4'hE, 4'h1, 4'h0, 4'h0, 8'h34, 1'b0, 1'b1};
        vt[7]  = '{20'h21920, 4'h2, 4'h1, 4'h0, 4'h0, 8'h20, 1'b0, 1'b1};
        vt[8]  = '{20'hA8100, 4'hA, 4'h8, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1};
        vt[9]  = '{20'hB8100, 4'hB, 4'h8, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1};
        vt[10] = '{20'h77700, 4'h7, 4'h7, 4'h7, 4'h0, 8'h00, 1'b1, 1'b0};
        vt[11] = '{20'hD0000, 4'hD, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1};
        vt[12] = '{20'hF0000, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1};
        vt[13] = '{20'hA5300, 4'hA, 4'h5, 4'h3, 4'h0, 8'h00, 1'b1, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst out_opcode", 32'(bus.out_opcode), 0);
        chk("rst out_dest", 32'(bus.out_dest), 0);
        chk("rst Reg1", 32'(bus.Reg1), 0);
        chk("rst Reg2", 32'(bus.Reg2), 0);
        chk("rst out_imm", 32'(bus.out_imm), 0);
        chk("rst out_we", 32'(bus.out_we), 0);
        chk("rst out_illegal", 32'(bus.out_illegal), 0);
        chk("rst scoreboard", 32'(dut.u_sb.pending), 0);
        chk("rst in_ready", 32'(bus.in_ready), 1);
`ifdef DECODE_PERF_CNT_EN
        chk("rst stall_cnt", 32'(stall_cnt), 0);
`endif

        // Decode table, each vector from a clean reset
        for (int i = 0; i < 14; i++) begin
            do_reset();
            bus.in_valid = 1'b1;
            bus.in_instr = vt[i].instr;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 1);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("v%0d opcode", i), 32'(bus.out_opcode), 32'(vt[i].opc));
            chk($sformatf("v%0d dest", i), 32'(bus.out_dest), 32'(vt[i].dest));
            chk($sformatf("v%0d Reg1", i), 32'(bus.Reg1), 32'(vt[i].r1));
            chk($sformatf("v%0d Reg2", i), 32'(bus.Reg2), 32'(vt[i].r2));
            chk($sformatf("v%0d imm", i), 32'(bus.out_imm), 32'(vt[i].imm));
            chk($sformatf("v%0d we", i), 32'(bus.out_we), 32'(vt[i].we));
            chk($sformatf("v%0d illegal", i), 32'(bus.out_illegal), 32'(vt[i].ill));
            tick();
            chk($sformatf("v%0d scoreboard", i), 32'(dut.u_sb.pending),
                vt[i].we ? (32'd1 << vt[i].dest) : 32'd0);
        end

        // RAW stall released by writeback in the same cycle
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 20'h13120;
        tick();
        bus.in_instr = 20'h14310;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("raw stall%0d in_ready", c), 32'(bus.in_ready), 0);
            tick();
        end
        chk("raw sb bit3", 32'(dut.u_sb.pending), 32'h08);
        bus.wb_valid = 1'b1;
        bus.wb_dest  = 4'h3;
        #1;
        chk("raw wb in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b0;
        chk("raw out_valid", 32'(bus.out_valid), 1);
        chk("raw out_dest", 32'(bus.out_dest), 4);
        chk("raw Reg1", 32'(bus.Reg1), 3);
        chk("raw sb cleared", 32'(dut.u_sb.pending), 0);
        tick();
        chk("raw sb bit4", 32'(dut.u_sb.pending), 32'h10);
`ifdef DECODE_PERF_CNT_EN
        chk("raw stall_cnt", 32'(stall_cnt), 3);
`endif

        // Backpressure: outputs stable while out_ready is low
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 20'h32100;
        tick();
        bus.in_instr = 20'h45670;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 0);
            chk($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 1);
            chk($sformatf("bp%0d out_dest", c), 32'(bus.out_dest), 2);
            chk($sformatf("bp%0d Reg1", c), 32'(bus.Reg1), 1);
            chk($sformatf("bp%0d opcode", c), 32'(bus.out_opcode), 3);
            tick();
        end
        chk("bp sb idle", 32'(dut.u_sb.pending), 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp next out_dest", 32'(bus.out_dest), 5);
        chk("bp next Reg1", 32'(bus.Reg1), 6);
        chk("bp next Reg2", 32'(bus.Reg2), 7);
        chk("bp sb bit2", 32'(dut.u_sb.pending), 32'h04);

        // Same-cycle set and clear of one bit: set wins
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 20'h15000;
        tick();
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_dest  = 4'h5;
        tick();
        chk("setclr bit5", 32'(dut.u_sb.pending), 32'h20);
        bus.wb_dest = 4'h2;
        tick();
        chk("wb clear bit ignored", 32'(dut.u_sb.pending), 32'h20);
        bus.wb_dest = 4'h5;
        tick();
        bus.wb_valid = 1'b0;
        chk("wb clears bit5", 32'(dut.u_sb.pending), 0);

        // Flush of a held instruction
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 20'h16000;
        tick();
        bus.flush    = 1'b1;
        bus.in_instr = 20'h12000;
        #1;
        chk("flush in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush out_valid", 32'(bus.out_valid), 0);
        chk("flush no capture", 32'(bus.out_dest), 6);
        chk("flush sb", 32'(dut.u_sb.pending), 0);
        bus.out_ready = 1'b1;
        tick();
        chk("flush sb later", 32'(dut.u_sb.pending), 0);

        // Illegal instruction bypasses hazard check; then reset mid-stall
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 20'h13120;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_instr = 20'h23390;
        #1;
        chk("illegal in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("illegal out_illegal", 32'(bus.out_illegal), 1);
        chk("illegal out_we", 32'(bus.out_we), 0);
        chk("illegal sb", 32'(dut.u_sb.pending), 32'h08);
        bus.in_instr = 20'h14310;
        tick();
        #1;
        chk("stall before reset", 32'(bus.in_ready), 0);
        chk("illegal sb after issue", 32'(dut.u_sb.pending), 32'h08);
        Reset = 1'b1;
        #1;
        chk("midreset sb", 32'(dut.u_sb.pending), 0);
        chk("midreset out_valid", 32'(bus.out_valid), 0);
        Reset = 1'b0;
        #1;
        chk("midreset in_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/issue stage directly upstream of the 8-entry x 20-bit register file.
- Accepts 20-bit instruction words from fetch, splits out opcode and fields, and drives the register file read addresses (Reg1, Reg2) plus destination/write-enable metadata to execute.
- Holds a scoreboard of pending register writes and stalls fetch on RAW/WAW hazards.
- Writeback (the source of the register file RW/Dest strobe) clears scoreboard bits.

Parameters:
- DW, 20, instruction/data width
- NREG, 8, architectural registers; field indices >= NREG are illegal
- AW, 4, register-index field width

Ports:
- clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept word this cycle
- in_instr  in  DW  instruction word
- flush  in  1  drop held and incoming instruction (branch redirect)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- out_opcode  out  4  instr[19:16]
- out_dest  out  AW  destination index
- Reg1  out  AW  register file read address 1
- Reg2  out  AW  register file read address 2
- out_imm  out  8  instr[7:0]
- out_we  out  1  instruction writes a register
- out_illegal  out  1  illegal opcode/index; instruction forced to NOP semantics
- wb_valid  in  1  writeback completing (same strobe as register file RW)
- wb_dest  in  AW  writeback destination

Behaviour:
- Reset (async, active-high): out_valid=0, out_opcode=0, out_dest=0, Reg1=0, Reg2=0, out_imm=0, out_we=0, out_illegal=0, scoreboard=0.
- Field map: dest=[15:12], src1=[11:8], src2=[7:4], imm=[7:0].
- Opcode classes:
  - 0x0 NOP: no reads, no write.
  - 0x1-0x7 ALU: reads src1, src2; writes dest.
  - 0x8 LDI: writes dest only.
  - 0x9 ADDI, 0xA LD: read src1; write dest.
  - 0xB ST: Reg1=src1 (base), Reg2=[15:12] (data); no write.
  - 0xC BEQ: reads src1, src2; no write.
  - 0xD-0xF: illegal.
- Unused read ports drive 0. Any used field >= NREG also makes the instruction illegal.
- Illegal instruction: out_illegal=1, out_we=0, no hazard check, no scoreboard effect.
- Hazard: a used source, or dest when out_we, matches either:
  - (scoreboard & ~wbclr), where wbclr is the one-hot of wb_dest when wb_valid, or
  - the held out_dest when out_valid && out_we.
- in_ready = (!out_valid || out_ready) && !hazard && !flush; combinational, no dependence on in_valid.
- Capture on in_valid && in_ready: output registers load next cycle, so latency is 1 cycle.
- Scoreboard set: bit out_dest is set when out_valid && out_ready && out_we. Clear: bit wb_dest when wb_valid. Same cycle, same bit: set wins.
- Output hold: while out_valid && !out_ready, all out_* and Reg1/Reg2 are stable.
- flush: next cycle out_valid=0; the held instruction is discarded and never enters the scoreboard; no capture in the flush cycle. Scoreboard bits of already-issued instructions persist.
- A wb_valid with the scoreboard bit already clear is ignored.
- Reset mid-stall clears everything; no pending hazards survive.

Optional Feature:
- DECODE_PERF_CNT_EN defined: adds output stall_cnt [15:0], reset to 0.
  - Increments each cycle with in_valid && hazard && !flush; saturates at 0xFFFF.
- Undefined: port and counter absent.

Decomposition:
- Shared package: opcode localparams (OP_NOP .. OP_BEQ), field bit positions, NREG/AW constants, a decoded-instruction struct/typedef (opcode, dest, src1, src2, imm, we, illegal).
- One sub-module: decode_scoreboard (NREG-bit pending vector; set/clear ports; combinational hazard query for three indices).

Test Plan:
- Reset, then ALU 0x1 dest=3 src1=1 src2=2 with out_ready=1 -> next cycle out_valid=1, Reg1=1, Reg2=2, out_dest=3, out_we=1; scoreboard bit3=1 after issue.
- RAW: issue dest=3, then instr reading src1=3 -> in_ready=0 until wb_valid with wb_dest=3; accepted in the same cycle as the writeback.
- Backpressure: out_ready=0 for 4 cycles -> outputs stable, in_ready=0; out_ready=1 -> one issue, then the next instruction is captured.
- Same-cycle set/clear: issue dest=5 while wb_valid wb_dest=5 -> bit5 remains 1.
- Flush while out_valid held (dest=6, out_ready=0) -> out_valid=0 next cycle, bit6=0, no capture that cycle.
- Illegal: opcode 0xE, then ALU with src1=9 -> out_illegal=1, out_we=0, no stall, scoreboard unchanged; with DECODE_PERF_CNT_EN, a 3-cycle RAW stall gives stall_cnt=3.
